axil_reg_bank: RTL

AXIL_REG_BANK -- requirements
Module: axil_reg_bank

---
 rtl/axil_reg_bank_pkg.sv | 47 ++++
 rtl/axil_reg_bank_decode.sv | 32 +++
 rtl/axil_reg_bank.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// axil_reg_bank_pkg
// Shared types and constants for the AXI-Lite register bank:
//   resp_e      AXI response codes (OKAY / SLVERR)
//   wr_state_e  write-path FSM states
//   rd_state_e  read-path FSM states
//   apply_strb  byte-lane merge of new data into an old register value
// ---------------------------------------------------------------------------
package axil_reg_bank_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_reg_bank_decode.sv
// ---------------------------------------------------------------------------
// axil_reg_bank_decode
// Combinational byte-address to register-index decode.
//   addr  in   ADDR_WIDTH  byte address
//   idx   out  IDX_WIDTH   register index ((addr - BASE_ADDR) >> 2)
//   err   out  1           address below base, unaligned, or past last reg
// ---------------------------------------------------------------------------
module axil_reg_bank_decode #(
    parameter int          NUM_REGS   = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32,
    parameter int          IDX_WIDTH  = 3
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;

    assign offset = addr - BASE;
    assign word   = offset >> 2;
    assign idx    = word[IDX_WIDTH-1:0];
    // The full word index is compared so that large offsets cannot alias
    // onto a valid register through the truncated idx.
    assign err    = (addr < BASE) || (addr[1:0] != 2'b00) || (word >= NREG);

endmodule

// File: rtl/axil_reg_bank.sv
// ---------------------------------------------------------------------------
// axil_reg_bank
// AXI-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Optional build macro: AXIL_REG_BANK_WSTRB_EN -- when defined, w_strb
// selects which byte lanes are written; otherwise all four lanes are written.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   aw_addr/aw_valid/aw_ready  write address channel
//   w_data/w_strb/w_valid/w_ready  write data channel
//   b_resp/b_valid/b_ready     write response channel
//   ar_addr/ar_valid/ar_ready  read address channel
//   r_data/r_resp/r_valid/r_ready  read data channel
//   reg_o                      flat register contents, reg i at [32i+31:32i]
//   wr_pulse_o                 one-cycle pulse per register after an OKAY write
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1. Ready outputs are registered and depend only on FSM state.
// ---------------------------------------------------------------------------
module axil_reg_bank
    import axil_reg_bank_pkg::*;
#(
    parameter int          NUM_REGS   = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_WIDTH-1:0]    aw_addr,
    input  logic                     aw_valid,
    output logic                     aw_ready,
    input  logic [DATA_WIDTH-1:0]    w_data,
    input  logic [STRB_WIDTH-1:0]    w_strb,
    input  logic                     w_valid,
    output logic                     w_ready,
    output logic [1:0]               b_resp,
    output logic                     b_valid,
    input  logic                     b_ready,
    input  logic [ADDR_WIDTH-1:0]    ar_addr,
    input  logic                     ar_valid,
    output logic                     ar_ready,
    output logic [DATA_WIDTH-1:0]    r_data,
    output logic [1:0]               r_resp,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [NUM_REGS*32-1:0]   reg_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int IDX_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    wr_state_e             wr_state;
    rd_state_e             rd_state;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] cmt_addr;
    logic [DATA_WIDTH-1:0] cmt_data;
    logic [STRB_WIDTH-1:0] cmt_strb;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic                  wr_err;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic                  rd_err;

    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;
    assign ar_hs = ar_valid && ar_ready;

    // Whichever half arrived earlier comes from its holding register; the
    // half completing on this edge comes straight from the bus.
    assign cmt_addr = (wr_state == WR_HAVE_AW) ? aw_addr_q : aw_addr;
    assign cmt_data = (wr_state == WR_HAVE_W) ? w_data_q : w_data;

`ifdef AXIL_REG_BANK_WSTRB_EN
    logic [STRB_WIDTH-1:0] w_strb_q;

    assign cmt_strb = (wr_state == WR_HAVE_W) ? w_strb_q : w_strb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_strb_q <= '0;
        end else if (wr_state == WR_IDLE && w_hs && !aw_hs) begin
            w_strb_q <= w_strb;
        end
    end
`else
    logic unused_strb;

    assign unused_strb = ^w_strb;
    assign cmt_strb    = '1;
`endif

    always_comb begin
        wr_commit = 1'b0;
        case (wr_state)
            WR_IDLE:    wr_commit = aw_hs && w_hs;
            WR_HAVE_AW: wr_commit = w_hs;
            WR_HAVE_W:  wr_commit = aw_hs;
            default:    wr_commit = 1'b0;
        endcase
    end

    axil_reg_bank_decode #(
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_wr_decode (
        .addr (cmt_addr),
        .idx  (wr_idx),
        .err  (wr_err)
    );

    axil_reg_bank_decode #(
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_rd_decode (
        .addr (ar_addr),
        .idx  (rd_idx),
        .err  (rd_err)
    );

    // Write-path FSM. Readies are registered and set on the transition into
    // the state that allows them, so they read 0 during reset and 1 from the
    // first cycle after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state  <= WR_IDLE;
            aw_ready  <= 1'b0;
            w_ready   <= 1'b0;
            b_valid   <= 1'b0;
            b_resp    <= OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state <= WR_RESP;
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b0;
                        b_valid  <= 1'b1;
                        b_resp   <= wr_err ? SLVERR : OKAY;
                    end else if (aw_hs) begin
                        wr_state  <= WR_HAVE_AW;
                        aw_addr_q <= aw_addr;
                        aw_ready  <= 1'b0;
                        w_ready   <= 1'b1;
                    end else if (w_hs) begin
                        wr_state <= WR_HAVE_W;
                        w_data_q <= w_data;
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b0;
                    end else begin
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                    end
                end
                WR_HAVE_AW: begin
                    if (w_hs) begin
                        wr_state <= WR_RESP;
                        w_ready  <= 1'b0;
                        b_valid  <= 1'b1;
                        b_resp   <= wr_err ? SLVERR : OKAY;
                    end
                end
                WR_HAVE_W: begin
                    if (aw_hs) begin
                        wr_state <= WR_RESP;
                        aw_ready <= 1'b0;
                        b_valid  <= 1'b1;
                        b_resp   <= wr_err ? SLVERR : OKAY;
                    end
                end
                WR_RESP: begin
                    if (b_ready) begin
                        wr_state <= WR_IDLE;
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                    end
                end
                default: begin
                    wr_state <= WR_IDLE;
                    aw_ready <= 1'b0;
                    w_ready  <= 1'b0;
                    b_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Register storage and write pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (wr_commit && !wr_err) begin
                regs[wr_idx]       <= apply_strb(regs[wr_idx], cmt_data, cmt_strb);
                wr_pulse_o[wr_idx] <= 1'b1;
            end
        end
    end

    // Read-path FSM. r_data samples regs before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= RD_RESP;
                        ar_ready <= 1'b0;
                        r_valid  <= 1'b1;
                        r_data   <= rd_err ? '0 : regs[rd_idx];
                        r_resp   <= rd_err ? SLVERR : OKAY;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (r_ready) begin
                        rd_state <= RD_IDLE;
                        r_valid  <= 1'b0;
                        ar_ready <= 1'b1;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                    ar_ready <= 1'b0;
                    r_valid  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_o
        assign reg_o[32*g +: 32] = regs[g];
    end

endmodule
